// File: rtl/wide_divider.sv
// wide_divider: multi-cycle restoring radix-2 divider, N / D -> Q, R.
// Sequencing: one CHECK cycle screens for errors, then QW iterations each
// produce one quotient bit, MSB first.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while idle
//   N            dividend (NW bits), captured on the accepting edge
//   D            divisor (DW bits), captured on the accepting edge
//   Q            quotient register (QW bits)
//   R            remainder register (DW bits)
//   ready        one-cycle pulse, results and flags valid from this cycle on
//   busy         high from the accepting edge until the edge that raises ready
//   div_by_zero  sticky flag, D was zero
//   overflow     sticky flag, quotient would not fit in QW bits
module wide_divider #(
  parameter int unsigned QW = 131,
  parameter int unsigned DW = 128,
  parameter int unsigned NW = 259
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] N,
  input  logic [DW-1:0] D,
  output logic [QW-1:0] Q,
  output logic [DW-1:0] R,
  output logic          ready,
  output logic          busy,
  output logic          div_by_zero,
  output logic          overflow
);

  if (NW != QW + DW) begin : gen_width_check
    $error("wide_divider: NW must equal QW + DW");
  end

  localparam int unsigned CW = $clog2(QW);

  typedef enum logic [1:0] {StIdle, StCheck, StIter} state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] nreg_q, nreg_d;
  logic [DW-1:0] dreg_q, dreg_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] n_hi;
  logic [QW-1:0] n_lo;
  logic [DW:0]   trial;
  logic [DW:0]   diff;
  logic          take;
  logic [DW-1:0] rem_next;
  logic [QW-1:0] quot_next;

  // One restoring step: bring down the next dividend bit and subtract if it fits.
  always_comb begin
    n_hi      = nreg_q[NW-1:QW];
    n_lo      = nreg_q[QW-1:0];
    trial     = {rem_q, n_lo[cnt_q]};
    take      = (trial >= {1'b0, dreg_q});
    diff      = trial - {1'b0, dreg_q};
    rem_next  = take ? diff[DW-1:0] : trial[DW-1:0];
    quot_next = {quot_q[QW-2:0], take};
  end

  always_comb begin
    state_d = state_q;
    nreg_d  = nreg_q;
    dreg_d  = dreg_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          nreg_d  = N;
          dreg_d  = D;
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (dreg_q == '0) begin
          dbz_d   = 1'b1;
          q_d     = '0;
          r_d     = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (n_hi >= dreg_q) begin
          // The high half already holds a full divisor: quotient needs > QW bits.
          ovf_d   = 1'b1;
          q_d     = '0;
          r_d     = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          rem_d   = n_hi;
          quot_d  = '0;
          cnt_d   = CW'(QW - 1);
          state_d = StIter;
        end
      end
      StIter: begin
        rem_d  = rem_next;
        quot_d = quot_next;
        if (cnt_q == '0) begin
          q_d     = quot_next;
          r_d     = rem_next;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      nreg_q  <= '0;
      dreg_q  <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nreg_q  <= nreg_d;
      dreg_q  <= dreg_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wide_divider.sv
// tb_wide_divider: directed and randomized checks of wide_divider against a
// transaction-level model that uses native wide / and %.
module tb_wide_divider;
  localparam int QW = 131;
  localparam int DW = 128;
  localparam int NW = 259;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] n_in;
  logic [DW-1:0] d_in;
  logic [QW-1:0] q;
  logic [DW-1:0] r;
  logic          ready;
  logic          busy;
  logic          dbz;
  logic          ovf;

  always #5 clk = ~clk;

  wide_divider #(.QW(QW), .DW(DW), .NW(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .N          (n_in),
    .D          (d_in),
    .Q          (q),
    .R          (r),
    .ready      (ready),
    .busy       (busy),
    .div_by_zero(dbz),
    .overflow   (ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model state
  bit            m_busy, m_ready, m_dbz, m_ovf;
  logic [QW-1:0] m_q, p_q;
  logic [DW-1:0] m_r, p_r;
  bit            p_dbz, p_ovf;
  int            m_left;

  task automatic model_accept(input logic [NW-1:0] n, input logic [DW-1:0] d);
    logic [NW-1:0] qf, rf, dw;
    logic [DW-1:0] top;
    top = n[NW-1:QW];
    dw  = {{(NW-DW){1'b0}}, d};
    p_dbz = 1'b0; p_ovf = 1'b0; p_q = '0; p_r = '0;
    if (d == '0) begin
      p_dbz = 1'b1; m_left = 1;
    end else if (top >= d) begin
      p_ovf = 1'b1; m_left = 1;
    end else begin
      qf = n / dw;
      rf = n % dw;
      p_q = qf[QW-1:0];
      p_r = rf[DW-1:0];
      m_left = QW + 1;
    end
  endtask

  initial begin
    m_busy = 0; m_ready = 0; m_dbz = 0; m_ovf = 0; m_q = '0; m_r = '0; m_left = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_ready = 0; m_dbz = 0; m_ovf = 0; m_q = '0; m_r = '0; m_left = 0;
      end else begin
        m_ready = 0;
        if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_dbz = 0; m_ovf = 0;
            model_accept(n_in, d_in);
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 0; m_ready = 1;
            m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        n_cmp++;
        if (busy !== m_busy || ready !== m_ready || dbz !== m_dbz || ovf !== m_ovf ||
            q !== m_q || r !== m_r) begin
          n_bad++;
          $display("FAIL cycle t=%0t busy=%b/%b ready=%b/%b dbz=%b/%b ovf=%b/%b Q=%h/%h R=%h/%h (got/want)",
                   $time, busy, m_busy, ready, m_ready, dbz, m_dbz, ovf, m_ovf, q, m_q, r, m_r);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] rand_n();
    logic [NW-1:0] v = '0;
    for (int i = 0; i < 9; i++) v = (v << 32) | NW'($urandom);
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_d();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < 4; i++) v = (v << 32) | DW'($urandom);
    return v;
  endfunction

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic launch(input logic [NW-1:0] n, input logic [DW-1:0] d);
    start = 1'b1; n_in = n; d_in = d;
    @(negedge clk);
    start = 1'b0; n_in = rand_n(); d_in = rand_d();
  endtask

  task automatic wait_ready(input bit inject, output int k);
    k = 0;
    while (ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (inject && ready !== 1'b1 && k < 100 && $urandom_range(0, 15) == 0) begin
        start = 1'b1; n_in = rand_n(); d_in = rand_d();
      end
    end
    if (ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout got=no_ready want=ready within 300 cycles");
    end
  endtask

  task automatic do_op(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic [QW-1:0] eq,
                       input logic [DW-1:0] er, input bit edbz, input bit eovf, input int ek);
    int k;
    launch(n, d);
    wait_ready(1'b0, k);
    chk("latency", k, ek);
    chk("Q", q, eq);
    chk("R", r, er);
    chk("div_by_zero", dbz, edbz);
    chk("overflow", ovf, eovf);
  endtask

  task automatic count_ready(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
  endtask

  initial begin
    logic [NW-1:0] t, a, b, n;
    logic [DW-1:0] d;
    int k, pulses, sel;
    rst = 1'b1; start = 1'b0; n_in = '0; d_in = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_Q", q, 0);
    chk("rst_R", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(100, 7, 14, 2, 0, 0, 132);
    do_op(12345, 0, 0, 0, 1, 0, 1);
    t = '0; t[NW-1] = 1'b1;
    do_op(t, 1, 0, 0, 0, 1, 1);
    t = NW'(5) << QW;
    do_op(t, 5, 0, 0, 0, 1, 1);
    do_op(t, 0, 0, 0, 1, 0, 1);

    a = {{(NW-QW){1'b0}}, {QW{1'b1}}};
    b = {{(NW-DW){1'b0}}, {DW{1'b1}}};
    t = a * b;
    do_op(t, {DW{1'b1}}, {QW{1'b1}}, 0, 0, 0, 132);
    do_op(t + NW'(5), {DW{1'b1}}, {QW{1'b1}}, 5, 0, 0, 132);

    // start while busy is ignored
    launch(1000, 3);
    k = 0;
    while (ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
      start = (k == 10);
      if (k == 10) begin n_in = 50; d_in = 5; end
    end
    start = 1'b0;
    chk("busy_restart_latency", k, 132);
    chk("busy_restart_Q", q, 333);
    chk("busy_restart_R", r, 1);
    count_ready(150, pulses);
    chk("busy_restart_pulses", pulses, 0);

    // back-to-back: start in the ready cycle
    launch(200, 7);
    wait_ready(1'b0, k);
    chk("b2b_first_Q", q, 28);
    chk("b2b_first_R", r, 4);
    launch(9, 3);
    wait_ready(1'b0, k);
    chk("b2b_latency", k, 132);
    chk("b2b_Q", q, 3);
    chk("b2b_R", r, 0);

    // reset in the middle of an operation
    launch(100, 7);
    for (int i = 0; i < 60; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_Q", q, 0);
    chk("midrst_R", r, 0);
    chk("midrst_flags", {dbz, ovf}, 0);
    rst = 1'b0;
    count_ready(200, pulses);
    chk("midrst_pulses", pulses, 0);
    do_op(100, 7, 14, 2, 0, 0, 132);

    // start held high restarts on every idle cycle
    start = 1'b1; n_in = 100; d_in = 7;
    count_ready(280, pulses);
    chk("hold_pulses", pulses, 2);
    start = 1'b0;
    wait_ready(1'b0, k);
    chk("hold_Q", q, 14);

    for (int it = 0; it < 40; it++) begin
      n = rand_n();
      d = rand_d();
      sel = $urandom_range(0, 9);
      if (sel == 0) d = '0;
      else if (sel == 1) d = DW'($urandom_range(1, 1000));
      if (sel >= 1 && sel != 3) n[NW-1:QW] = n[NW-1:QW] % d;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      launch(n, d);
      wait_ready(1'b1, k);
      if (!dbz && !ovf) begin
        chk("invariant", {{(NW-QW){1'b0}}, q} * {{(NW-DW){1'b0}}, d} + {{(NW-DW){1'b0}}, r}, n);
        chk("rem_lt_div", r < d, 1);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
